i2c_arbiter: RTL and testbench

- Shares the single i2c_core between two requesters: A (UART control path) and B (periodic RTC poller).
- Round-robin grant; issues the start pulse and transaction descriptor to i2c_core; steers write/read bytes to the granted requester.
- Tracks completion by byte count, enforces a bus-free gap and a progress timeout, and reports done/error per transaction.

---
 rtl/i2c_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_i2c_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_arbiter
//  Purpose  : Round-robin sharing of one i2c_core between requester A (UART
//             control path) and requester B (RTC poller). Issues the start
//             pulse and descriptor, steers byte handshakes to the owner,
//             enforces a bus-free gap and a progress timeout.
//  Revision : 1.0  initial release
// ============================================================================
module i2c_arbiter #(
  parameter int GAP_CYCLES     = 64,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       rw_a,
  input  logic       rw_b,
  input  logic [6:0] addr_a,
  input  logic [6:0] addr_b,
  input  logic [7:0] nbytes_a,
  input  logic [7:0] nbytes_b,
  input  logic       wdata_valid_a,
  input  logic       wdata_valid_b,
  input  logic [7:0] wdata_a,
  input  logic [7:0] wdata_b,
  output logic       wdata_ready_a,
  output logic       wdata_ready_b,
  output logic       rdata_valid_a,
  output logic       rdata_valid_b,
  output logic [7:0] rdata_a,
  output logic [7:0] rdata_b,
  output logic       grant_a,
  output logic       grant_b,
  output logic       done_a,
  output logic       done_b,
  output logic       err,
  output logic       i2c_en,
  output logic       i2c_rw,
  output logic [6:0] i2c_addr,
  output logic [7:0] i2c_byte_read,
  output logic       i2c_in_valid,
  output logic [7:0] i2c_in_data,
  input  logic       i2c_in_ready,
  input  logic       i2c_out_valid,
  input  logic [7:0] i2c_out_data
);

  localparam int c_timer_w = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int c_gap_w   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [c_timer_w-1:0] c_tmo_last = c_timer_w'(TIMEOUT_CYCLES - 1);
  localparam logic [c_gap_w-1:0]   c_gap_last = c_gap_w'(GAP_CYCLES - 1);
  // With a one-cycle gap the done pulse must be raised on entry to GAP.
  localparam bit c_gap_one = (GAP_CYCLES == 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_XFER  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t               r_state;
  logic                 r_grant_a;
  logic                 r_grant_b;
  logic                 r_last_b;      // 1 = B was granted most recently
  logic                 r_rw;
  logic [6:0]           r_addr;
  logic [7:0]           r_nbytes;
  logic [7:0]           r_cnt;
  logic [c_timer_w-1:0] r_timer;
  logic [c_gap_w-1:0]   r_gap;
  logic                 r_abort;
  logic                 r_done_a;
  logic                 r_done_b;
  logic                 r_err;
  logic                 r_en;

  logic                 w_xfer_wr;
  logic                 w_xfer_rd;
  logic                 w_wvalid;
  logic [7:0]           w_wdata;
  logic                 w_hs;
  logic                 w_pick_b;
  logic [7:0]           w_cnt_inc;
  logic [c_gap_w-1:0]   w_gap_inc;

  // Byte steering: only the owner sees handshakes, and only while in XFER.
  always_comb begin
    w_xfer_wr = (r_state == S_XFER) && !r_rw;
    w_xfer_rd = (r_state == S_XFER) && r_rw;
    w_wvalid  = 1'b0;
    w_wdata   = 8'h00;
    if (r_grant_a) begin
      w_wvalid = wdata_valid_a;
      w_wdata  = wdata_a;
    end else if (r_grant_b) begin
      w_wvalid = wdata_valid_b;
      w_wdata  = wdata_b;
    end
    w_hs      = (w_xfer_wr && w_wvalid && i2c_in_ready) || (w_xfer_rd && i2c_out_valid);
    // B wins when it is alone, or on a tie when A went last.
    w_pick_b  = req_b && (!req_a || !r_last_b);
    w_cnt_inc = r_cnt + 8'd1;
    w_gap_inc = r_gap + 1'b1;
  end

  assign i2c_in_valid  = w_xfer_wr && w_wvalid;
  assign i2c_in_data   = w_xfer_wr ? w_wdata : 8'h00;
  assign wdata_ready_a = i2c_in_ready && r_grant_a && w_xfer_wr;
  assign wdata_ready_b = i2c_in_ready && r_grant_b && w_xfer_wr;
  assign rdata_valid_a = i2c_out_valid && r_grant_a && w_xfer_rd;
  assign rdata_valid_b = i2c_out_valid && r_grant_b && w_xfer_rd;
  assign rdata_a       = i2c_out_data;
  assign rdata_b       = i2c_out_data;
  assign grant_a       = r_grant_a;
  assign grant_b       = r_grant_b;
  assign done_a        = r_done_a;
  assign done_b        = r_done_b;
  assign err           = r_err;
  assign i2c_en        = r_en;
  assign i2c_rw        = r_rw;
  assign i2c_addr      = r_addr;
  assign i2c_byte_read = r_nbytes;

  // Transaction sequencer: arbitrate, start, count bytes, timeout, gap, done.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_grant_a <= 1'b0;
      r_grant_b <= 1'b0;
      r_last_b  <= 1'b1;
      r_rw      <= 1'b0;
      r_addr    <= 7'h00;
      r_nbytes  <= 8'h00;
      r_cnt     <= 8'h00;
      r_timer   <= '0;
      r_gap     <= '0;
      r_abort   <= 1'b0;
      r_done_a  <= 1'b0;
      r_done_b  <= 1'b0;
      r_err     <= 1'b0;
      r_en      <= 1'b0;
    end else begin
      r_en     <= 1'b0;
      r_done_a <= 1'b0;
      r_done_b <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_a || req_b) begin
            r_grant_a <= !w_pick_b;
            r_grant_b <= w_pick_b;
            r_last_b  <= w_pick_b;
            r_rw      <= w_pick_b ? rw_b     : rw_a;
            r_addr    <= w_pick_b ? addr_b   : addr_a;
            r_nbytes  <= w_pick_b ? nbytes_b : nbytes_a;
            r_state   <= S_START;
          end
        end
        S_START: begin
          r_en    <= 1'b1;
          r_cnt   <= 8'h00;
          r_timer <= '0;
          r_gap   <= '0;
          if (r_nbytes == 8'h00) begin
            r_state <= S_GAP;
            if (c_gap_one) begin
              r_done_a <= r_grant_a;
              r_done_b <= r_grant_b;
            end
          end else begin
            r_state <= S_XFER;
          end
        end
        S_XFER: begin
          if (w_hs) begin
            r_cnt   <= w_cnt_inc;
            r_timer <= '0;
            if (w_cnt_inc == r_nbytes) begin
              r_state <= S_GAP;
              if (c_gap_one) begin
                r_done_a <= r_grant_a;
                r_done_b <= r_grant_b;
              end
            end
          end else if (r_timer == c_tmo_last) begin
            r_abort <= 1'b1;
            r_state <= S_GAP;
            if (c_gap_one) begin
              r_done_a <= r_grant_a;
              r_done_b <= r_grant_b;
              r_err    <= 1'b1;
            end
          end else begin
            // Leaves XFER at c_tmo_last, so the timer never wraps.
            r_timer <= r_timer + 1'b1;
          end
        end
        S_GAP: begin
          if (r_gap == c_gap_last) begin
            r_state   <= S_IDLE;
            r_grant_a <= 1'b0;
            r_grant_b <= 1'b0;
            r_abort   <= 1'b0;
          end else begin
            r_gap <= w_gap_inc;
            if (w_gap_inc == c_gap_last) begin
              r_done_a <= r_grant_a;
              r_done_b <= r_grant_b;
              r_err    <= r_abort;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_i2c_arbiter
//  Purpose  : Randomized self-checking bench for i2c_arbiter with a
//             transaction-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_i2c_arbiter;

  localparam int c_gap = 8;
  localparam int c_tmo = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_a = 0, req_b = 0, rw_a = 0, rw_b = 0;
  logic [6:0] addr_a = 0, addr_b = 0;
  logic [7:0] nbytes_a = 0, nbytes_b = 0;
  logic       wdata_valid_a = 0, wdata_valid_b = 0;
  logic [7:0] wdata_a = 0, wdata_b = 0;
  logic       wdata_ready_a, wdata_ready_b, rdata_valid_a, rdata_valid_b;
  logic [7:0] rdata_a, rdata_b;
  logic       grant_a, grant_b, done_a, done_b, err;
  logic       i2c_en, i2c_rw, i2c_in_valid;
  logic [6:0] i2c_addr;
  logic [7:0] i2c_byte_read, i2c_in_data;
  logic       i2c_in_ready = 0, i2c_out_valid = 0;
  logic [7:0] i2c_out_data = 0;

  always #5 clk = ~clk;

  i2c_arbiter #(.GAP_CYCLES(c_gap), .TIMEOUT_CYCLES(c_tmo)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .req_b(req_b), .rw_a(rw_a), .rw_b(rw_b),
    .addr_a(addr_a), .addr_b(addr_b), .nbytes_a(nbytes_a), .nbytes_b(nbytes_b),
    .wdata_valid_a(wdata_valid_a), .wdata_valid_b(wdata_valid_b),
    .wdata_a(wdata_a), .wdata_b(wdata_b),
    .wdata_ready_a(wdata_ready_a), .wdata_ready_b(wdata_ready_b),
    .rdata_valid_a(rdata_valid_a), .rdata_valid_b(rdata_valid_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b),
    .grant_a(grant_a), .grant_b(grant_b), .done_a(done_a), .done_b(done_b), .err(err),
    .i2c_en(i2c_en), .i2c_rw(i2c_rw), .i2c_addr(i2c_addr), .i2c_byte_read(i2c_byte_read),
    .i2c_in_valid(i2c_in_valid), .i2c_in_data(i2c_in_data), .i2c_in_ready(i2c_in_ready),
    .i2c_out_valid(i2c_out_valid), .i2c_out_data(i2c_out_data)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit m_last_b = 1'b1;   // model: who was granted last (reset value B)

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Every registered and combinational output that must be quiet in IDLE.
  task automatic check_quiet(input string tag);
    check({tag, "_ctl"}, {grant_a, grant_b, done_a, done_b, err, i2c_en, i2c_rw, i2c_in_valid}, 0);
    check({tag, "_desc"}, {i2c_addr, i2c_byte_read}, 0);
    check({tag, "_hs"}, {wdata_ready_a, wdata_ready_b, rdata_valid_a, rdata_valid_b}, 0);
  endtask

  task automatic setreq(input bit ra, input bit rb,
                        input bit rwa, input logic [6:0] aa, input logic [7:0] na,
                        input bit rwb, input logic [6:0] ab, input logic [7:0] nb);
    @(posedge clk); #1;
    req_a = ra; rw_a = rwa; addr_a = aa; nbytes_a = na;
    req_b = rb; rw_b = rwb; addr_b = ab; nbytes_b = nb;
    i2c_in_ready = 0; i2c_out_valid = 0;
    wdata_valid_a = 0; wdata_valid_b = 0;
  endtask

  // Runs one complete transaction against the model. Called in the IDLE
  // cycle in which the requests have just been driven.
  task automatic serve(input int stall_after);
    bit wb, erw, ab, inx, first, stalled, rdy, ov, wv, hs;
    logic [6:0] ea;
    logic [7:0] en, od, wd;
    int cnt, idle, gapn, last_hs;
    wb  = req_b && (!req_a || !m_last_b);
    erw = wb ? rw_b : rw_a;
    ea  = wb ? addr_b : addr_a;
    en  = wb ? nbytes_b : nbytes_a;
    @(negedge clk);
    check("idle_grant", {grant_a, grant_b}, 0);
    // Grant / START cycle: scramble the winner's descriptor to prove it was latched.
    @(posedge clk); #1;
    i2c_in_ready = 1'($urandom); i2c_out_valid = 1'($urandom); i2c_out_data = 8'($urandom);
    if (wb) begin rw_b = 1'($urandom); addr_b = 7'($urandom); nbytes_b = 8'($urandom_range(0, 7)); end
    else    begin rw_a = 1'($urandom); addr_a = 7'($urandom); nbytes_a = 8'($urandom_range(0, 7)); end
    m_last_b = wb;
    @(negedge clk);
    check("grant", {grant_a, grant_b}, wb ? 2'b01 : 2'b10);
    check("en_late", i2c_en, 0);
    check("start_hs", {wdata_ready_a, wdata_ready_b, rdata_valid_a, rdata_valid_b, i2c_in_valid}, 0);
    cnt = 0; idle = 0; gapn = 0; ab = 0; inx = (en != 0); first = 1; last_hs = cyc;
    for (int k = 0; k < 5000; k++) begin
      @(posedge clk); #1;
      stalled = (stall_after >= 0) && (cnt >= stall_after);
      if (inx && stalled) begin rdy = 0; ov = 0; end
      else begin rdy = ($urandom_range(0, 2) == 0); ov = ($urandom_range(0, 2) == 0); end
      if (!inx && gapn < 2) begin rdy = 1; ov = 1; end  // stray core activity after the last byte
      od = 8'($urandom); wd = 8'($urandom); wv = ($urandom_range(0, 3) != 0);
      i2c_in_ready = rdy; i2c_out_valid = ov; i2c_out_data = od;
      if (wb) begin wdata_valid_b = wv; wdata_b = wd; wdata_valid_a = 1'($urandom); wdata_a = 8'($urandom); end
      else    begin wdata_valid_a = wv; wdata_a = wd; wdata_valid_b = 1'($urandom); wdata_b = 8'($urandom); end
      @(negedge clk);
      if (first) begin
        check("en", i2c_en, 1);
        check("desc", {i2c_rw, i2c_addr, i2c_byte_read}, {erw, ea, en});
      end else begin
        check("en_once", i2c_en, 0);
      end
      first = 0;
      check("owner", wb ? {grant_b, grant_a} : {grant_a, grant_b}, 2'b10);
      check("other_quiet", wb ? {wdata_ready_a, rdata_valid_a, done_a} : {wdata_ready_b, rdata_valid_b, done_b}, 0);
      if (inx) begin
        check("wready", wb ? wdata_ready_b : wdata_ready_a, !erw && rdy);
        check("rvalid", wb ? rdata_valid_b : rdata_valid_a, erw && ov);
        if (erw && ov) check("rdata", wb ? rdata_b : rdata_a, od);
        check("in_valid", i2c_in_valid, !erw && wv);
        if (!erw && wv) check("in_data", i2c_in_data, wd);
        check("done_early", wb ? done_b : done_a, 0);
        hs = erw ? ov : (rdy && wv);
        if (hs) begin
          cnt++; idle = 0; last_hs = cyc;
          if (cnt == int'(en)) inx = 0;
        end else if (idle == c_tmo - 1) begin
          ab = 1; inx = 0;
        end else begin
          idle++;
        end
      end else begin
        gapn++;
        check("gap_quiet", {wb ? wdata_ready_b : wdata_ready_a, wb ? rdata_valid_b : rdata_valid_a, i2c_in_valid}, 0);
        check("done", wb ? done_b : done_a, gapn == c_gap);
        if (gapn == c_gap) begin
          check("err", err, ab);
          if (ab) check("tmo_latency", cyc - last_hs, c_tmo + c_gap);
          else    check("done_latency", cyc - last_hs, c_gap);
          break;
        end
      end
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ra, rb;
    reset = 1;
    i2c_in_ready = 1; i2c_out_valid = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk); #1;
    reset = 0;

    // Tie from reset: A first, then B with A still held, then the next tie to A.
    setreq(1, 1, 0, 7'h68, 8'd3, 1, 7'h51, 8'd7); serve(-1);
    setreq(1, 1, 0, 7'h68, 8'd2, 1, 7'h51, 8'd7); serve(-1);
    setreq(1, 1, 1, 7'h22, 8'd4, 0, 7'h51, 8'd3); serve(-1);
    // Timeout after one byte of a two-byte read, then a clean transaction.
    setreq(1, 0, 1, 7'h3c, 8'd2, 0, 7'h00, 8'd0); serve(1);
    setreq(0, 1, 0, 7'h00, 8'd0, 0, 7'h51, 8'd4); serve(-1);
    // Address-only probe and a short read with stray strobes afterwards.
    setreq(0, 1, 0, 7'h00, 8'd0, 1, 7'h50, 8'd0); serve(-1);
    setreq(1, 0, 1, 7'h11, 8'd2, 0, 7'h00, 8'd0); serve(-1);
    // Write timeout with no bytes at all.
    setreq(0, 1, 0, 7'h00, 8'd0, 0, 7'h12, 8'd3); serve(0);

    for (int i = 0; i < 14; i++) begin
      ra = 1'($urandom);
      rb = ra ? 1'($urandom) : 1'b1;
      setreq(ra, rb, 1'($urandom), 7'($urandom), 8'($urandom_range(0, 6)),
             1'($urandom), 7'($urandom), 8'($urandom_range(0, 6)));
      serve(($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 2)) : -1);
    end

    // Reset in the middle of a write transfer.
    setreq(1, 0, 0, 7'h2a, 8'd5, 0, 7'h00, 8'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre_reset_grant", grant_a, 1);
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0; req_a = 0;
    i2c_in_ready = 1; wdata_valid_a = 1;
    @(negedge clk);
    check_quiet("midrst");
    m_last_b = 1'b1;
    for (int i = 0; i < c_gap + 3; i++) begin
      @(negedge clk);
      check("midrst_nodone", {done_a, done_b, grant_a, grant_b}, 0);
    end
    // After reset, a tie must go to A again.
    setreq(1, 1, 0, 7'h2a, 8'd2, 1, 7'h51, 8'd1); serve(-1);
    setreq(0, 1, 0, 7'h00, 8'd0, 1, 7'h51, 8'd1); serve(-1);
    setreq(0, 0, 0, 7'h00, 8'd0, 0, 7'h00, 8'd0);
    @(negedge clk);
    check("final_idle", {grant_a, grant_b}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
